// File: rtl/nibble_add_sequencer_pkg.sv
// nibble_add_sequencer_pkg: nibble width and FSM state encodings shared by the sequencer
package nibble_add_sequencer_pkg;
   localparam int NIBBLE_W = 4;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/nibble_add_sequencer_full_adder_4bit.sv
// full_adder_4bit: combinational 4-bit adder with carry in/out
module full_adder_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);
   assign {cout, s} = a + b + cin;
endmodule

// File: rtl/nibble_add_sequencer.sv
// nibble_add_sequencer: serial multi-precision add/subtract, one nibble per cycle LSB first
// through a single shared 4-bit adder, with valid/ready command and result ports.
module nibble_add_sequencer
   import nibble_add_sequencer_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_sub,
   input  logic [NIBBLE_W*NIBBLES-1:0] op_a,
   input  logic [NIBBLE_W*NIBBLES-1:0] op_b,
   input  logic                       abort,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [NIBBLE_W*NIBBLES-1:0] result,
   output logic                       carry_out,
   output logic                       overflow
);
   localparam int W  = NIBBLE_W * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   state_t state, state_n;
   logic [W-1:0] a, b;
   logic [IW-1:0] idx;
   logic carry, cout, last;
   logic [NIBBLE_W-1:0] sum;
   assign last      = idx == IW'(NIBBLES - 1);
   assign cmd_ready = rst_n && state == ST_IDLE;
   assign res_valid = state == ST_DONE;
   full_adder_4bit u_add (
      .a   (a[idx*NIBBLE_W +: NIBBLE_W]),
      .b   (b[idx*NIBBLE_W +: NIBBLE_W]),
      .cin (carry),
      .s   (sum),
      .cout(cout)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_n;
   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: state_n = cmd_valid ? ST_RUN : ST_IDLE;
         ST_RUN:  state_n = abort ? ST_IDLE : (last ? ST_DONE : ST_RUN);
         ST_DONE: state_n = (abort || res_ready) ? ST_IDLE : ST_DONE;
         default: state_n = ST_IDLE;
      endcase
   end
   // b holds the effective operand: inverted for subtract, with the +1 entering as the initial carry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a         <= '0;
         b         <= '0;
         idx       <= '0;
         carry     <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else if (state == ST_IDLE && cmd_valid) begin
         a      <= op_a;
         b      <= cmd_sub ? ~op_b : op_b;
         carry  <= cmd_sub;
         idx    <= '0;
         result <= '0;
      end else if (state == ST_RUN && !abort) begin
         result[idx*NIBBLE_W +: NIBBLE_W] <= sum;
         carry <= cout;
         if (last) begin
            carry_out <= cout;
            overflow  <= (a[W-1] == b[W-1]) && (sum[NIBBLE_W-1] != a[W-1]);
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_nibble_add_sequencer.sv
// tb_nibble_add_sequencer: randomized and directed checks of the serial adder against an arithmetic model
module tb_nibble_add_sequencer;
   localparam int N = 4;
   localparam int W = 4 * N;
   logic clk = 1'b0, rst_n = 1'b0;
   logic cmd_valid = 1'b0, cmd_sub = 1'b0, abort = 1'b0, res_ready = 1'b0;
   logic [W-1:0] op_a = '0, op_b = '0;
   logic cmd_ready, res_valid, carry_out, overflow;
   logic [W-1:0] result;
   int pass_cnt = 0, total = 0;

   nibble_add_sequencer #(.NIBBLES(N)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_sub(cmd_sub), .op_a(op_a), .op_b(op_b), .abort(abort),
      .res_valid(res_valid), .res_ready(res_ready), .result(result),
      .carry_out(carry_out), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // returns {overflow, carry, result} from plain integer arithmetic
   function automatic logic [W+1:0] model(input logic [W-1:0] x, y, input logic sub);
      int sx, sy, s;
      logic [W-1:0] r;
      logic c, v;
      sx = int'($signed(x));
      sy = int'($signed(y));
      s  = sub ? sx - sy : sx + sy;
      r  = sub ? x - y : x + y;
      c  = sub ? (x >= y) : ((int'(x) + int'(y)) >= (1 << W));
      v  = (s > 32767) || (s < -32768);
      return {v, c, r};
   endfunction

   task automatic issue(input logic [W-1:0] x, y, input logic sub);
      op_a = x; op_b = y; cmd_sub = sub; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0; op_a = W'($urandom); op_b = W'($urandom); cmd_sub = 1'($urandom);
   endtask

   task automatic wait_res(output int lat);
      lat = 0;
      while (!res_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!res_valid) lat = -1;
   endtask

   task automatic test_reset;
      #1;
      total++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready got %b exp 0", cmd_ready); else pass_cnt++;
      total++; if ({res_valid, carry_out, overflow, result} !== '0) $display("FAIL reset_outputs got %b%b%b_%h exp 0", res_valid, carry_out, overflow, result); else pass_cnt++;
      #13 rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (cmd_ready !== 1'b1) $display("FAIL release_cmd_ready got %b exp 1", cmd_ready); else pass_cnt++;
   endtask

   task automatic test_vectors;
      logic [W-1:0] va [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
      logic [W-1:0] vb [5] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
      logic         vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [W-1:0] vr [5] = '{16'h2233, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
      logic         vc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic         vv [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      int lat;
      res_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         issue(va[i], vb[i], vs[i]);
         wait_res(lat);
         total++; if (lat !== N) $display("FAIL vec%0d_latency got %0d exp %0d", i, lat, N); else pass_cnt++;
         total++; if ({overflow, carry_out, result} !== {vv[i], vc[i], vr[i]})
            $display("FAIL vec%0d_value got v%b c%b %h exp v%b c%b %h", i, overflow, carry_out, result, vv[i], vc[i], vr[i]);
         else pass_cnt++;
         @(posedge clk); #1;
         total++; if ({cmd_ready, res_valid} !== 2'b10) $display("FAIL vec%0d_bubble got rdy%b val%b exp rdy1 val0", i, cmd_ready, res_valid); else pass_cnt++;
      end
      res_ready = 1'b0;
   endtask

   task automatic test_backpressure;
      logic [W+1:0] exp, held;
      int lat, bad;
      exp = model(16'h4321, 16'h1111, 1'b1);
      issue(16'h4321, 16'h1111, 1'b1);
      wait_res(lat);
      total++; if (lat !== N) $display("FAIL bp_latency got %0d exp %0d", lat, N); else pass_cnt++;
      held = {overflow, carry_out, result};
      total++; if (held !== exp) $display("FAIL bp_value got %h exp %h", held, exp); else pass_cnt++;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         op_a = W'($urandom); op_b = W'($urandom); cmd_sub = 1'($urandom); cmd_valid = 1'b1;
         @(posedge clk); #1;
         if (!res_valid || cmd_ready || {overflow, carry_out, result} !== exp) bad++;
      end
      cmd_valid = 1'b0;
      total++; if (bad !== 0) $display("FAIL bp_stable got %0d bad cycles exp 0", bad); else pass_cnt++;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      total++; if ({cmd_ready, res_valid} !== 2'b10) $display("FAIL bp_release got rdy%b val%b exp rdy1 val0", cmd_ready, res_valid); else pass_cnt++;
   endtask

   task automatic test_abort;
      int lat, seen;
      issue(16'h1111, 16'hFFFF, 1'b0);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      total++; if ({cmd_ready, res_valid} !== 2'b10) $display("FAIL abort_idle got rdy%b val%b exp rdy1 val0", cmd_ready, res_valid); else pass_cnt++;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (res_valid) seen++;
      end
      total++; if (seen !== 0) $display("FAIL abort_no_valid got %0d exp 0", seen); else pass_cnt++;
      issue(16'h0001, 16'h0001, 1'b0);
      wait_res(lat);
      total++; if ({lat, overflow, carry_out, result} !== {N, 1'b0, 1'b0, 16'h0002})
         $display("FAIL abort_next got lat%0d v%b c%b %h exp lat%0d v0 c0 0002", lat, overflow, carry_out, result, N);
      else pass_cnt++;
      // abort beats res_ready in DONE
      abort = 1'b1; res_ready = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; res_ready = 1'b0;
      total++; if ({cmd_ready, res_valid} !== 2'b10) $display("FAIL abort_done got rdy%b val%b exp rdy1 val0", cmd_ready, res_valid); else pass_cnt++;
   endtask

   task automatic test_async_reset;
      int lat;
      res_ready = 1'b1;
      issue(16'h7FFF, 16'h0001, 1'b0);
      wait_res(lat);
      @(posedge clk); #1;
      res_ready = 1'b0;
      issue(16'hFFFF, 16'hFFFF, 1'b0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      total++; if ({cmd_ready, res_valid, carry_out, overflow, result} !== '0)
         $display("FAIL async_reset got rdy%b val%b c%b v%b %h exp all 0", cmd_ready, res_valid, carry_out, overflow, result);
      else pass_cnt++;
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      issue(16'h00FF, 16'h0001, 1'b0);
      wait_res(lat);
      total++; if ({lat, overflow, carry_out, result} !== {N, 1'b0, 1'b0, 16'h0100})
         $display("FAIL after_reset got lat%0d v%b c%b %h exp lat%0d v0 c0 0100", lat, overflow, carry_out, result, N);
      else pass_cnt++;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   task automatic test_random;
      logic [W-1:0] x, y;
      logic s;
      logic [W+1:0] exp;
      int lat, hold;
      for (int i = 0; i < 40; i++) begin
         x = W'($urandom); y = W'($urandom); s = 1'($urandom);
         if (i < 4) y = (i[0]) ? x : 16'h8000;
         exp = model(x, y, s);
         issue(x, y, s);
         wait_res(lat);
         total++; if (lat !== N) $display("FAIL rand%0d_latency got %0d exp %0d", i, lat, N); else pass_cnt++;
         total++; if ({overflow, carry_out, result} !== exp)
            $display("FAIL rand%0d_value %h %s %h got v%b c%b %h exp v%b c%b %h", i, x, s ? "-" : "+", y, overflow, carry_out, result, exp[W+1], exp[W], exp[W-1:0]);
         else pass_cnt++;
         hold = $urandom_range(0, 3);
         repeat (hold) begin @(posedge clk); #1; end
         res_ready = 1'b1;
         @(posedge clk); #1;
         res_ready = 1'b0;
      end
   endtask

   initial begin
      test_reset;
      test_vectors;
      test_backpressure;
      test_abort;
      test_async_reset;
      test_random;
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
